// File: rtl/bp_commit_tracker.sv
// In-order record of predicted branches between fetch and ROB commit; pops the
// oldest record on each commit and drives the registered predictor-update triple.
module bp_commit_tracker #(
  parameter int DEPTH_LOG = 4,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_fetch_push,
  input  logic [TAG_W-1:0] in_fetch_tag,
  input  logic             in_fetch_pred,
  output logic             out_fetch_full,
  input  logic             in_rob_commit,
  input  logic             in_rob_taken,
  input  logic             in_flush,
  output logic             out_bp_res,
  output logic [TAG_W-1:0] out_bp_tag,
  output logic             out_bp_jump_res,
  output logic             out_mispredict,
  output logic             out_err_underflow,
  output logic [CNT_W-1:0] out_branch_cnt,
  output logic [CNT_W-1:0] out_miss_cnt
);

  localparam int                   DEPTH      = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_LOG:0]   COUNT_ONE  = 1;
  localparam logic [CNT_W-1:0]     STAT_ONE   = 1;

  logic [TAG_W-1:0]     tag_mem  [DEPTH];
  logic                 pred_mem [DEPTH];

  logic [DEPTH_LOG-1:0] head, tail;
  logic [DEPTH_LOG-1:0] head_next, tail_next;
  logic [DEPTH_LOG:0]   count, count_next;

  logic commit_req, commit_ok, underflow, miss, clear, push_ok;
  logic head_pred;
  logic [TAG_W-1:0] head_tag;

  assign out_fetch_full = (count == FULL_COUNT);

  assign head_pred  = pred_mem[head];
  assign head_tag   = tag_mem[head];
  assign commit_req = rdy & in_rob_commit;
  assign commit_ok  = commit_req & (count != '0);
  assign underflow  = commit_req & (count == '0);
  assign miss       = commit_ok & (head_pred != in_rob_taken);
  // A mispredict or flush makes every younger record wrong-path, including a same-cycle push.
  assign clear      = miss | (rdy & in_flush);
  assign push_ok    = rdy & in_fetch_push & ~clear & (~out_fetch_full | commit_ok);

  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (commit_ok) head_next = head + PTR_ONE;
    if (clear) begin
      tail_next  = head_next;
      count_next = '0;
    end else begin
      if (push_ok) tail_next = tail + PTR_ONE;
      case ({push_ok, commit_ok})
        2'b10:   count_next = count + COUNT_ONE;
        2'b01:   count_next = count - COUNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      tag_mem[tail]  <= in_fetch_tag;
      pred_mem[tail] <= in_fetch_pred;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      out_bp_res        <= 1'b0;
      out_bp_tag        <= '0;
      out_bp_jump_res   <= 1'b0;
      out_mispredict    <= 1'b0;
      out_err_underflow <= 1'b0;
      out_branch_cnt    <= '0;
      out_miss_cnt      <= '0;
    end else begin
      // With rdy low every event term is gated off, so state holds and pulses drop.
      head           <= head_next;
      tail           <= tail_next;
      count          <= count_next;
      out_bp_res     <= commit_ok;
      out_mispredict <= miss;
      if (commit_ok) begin
        out_bp_tag      <= head_tag;
        out_bp_jump_res <= in_rob_taken;
      end
      if (underflow) out_err_underflow <= 1'b1;
      if (commit_ok && !(&out_branch_cnt)) out_branch_cnt <= out_branch_cnt + STAT_ONE;
      if (miss && !(&out_miss_cnt)) out_miss_cnt <= out_miss_cnt + STAT_ONE;
    end
  end

endmodule
